arrive_depart_counter: RTL and testbench
========================================

Name: arrive_depart_counter

Overview:
Parametrised occupancy counter that generalises the 1-bit Counter_1bit to an N-bit up/down counter. It counts arrivals and departures from two asynchronous level inputs, such as vehicle or object sensors. Each input is synchronised and rising-edge detected, so one held pulse counts once. The count saturates at 0 and at CAPACITY, with Full/Empty status and one-cycle overflow/underflow error strobes. It sits between the sensor inputs and the display/control logic.

Parameters:
WIDTH, 4, bit width of Count; must satisfy 2**WIDTH-1 >= CAPACITY
CAPACITY, 10, maximum legal count; Full asserts at this value
SYNC_STAGES, 2, flops in each input synchroniser; minimum 2

Ports:
Clock  input  1  single system clock; all state changes on its rising edge
Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock
Arrive  input  1  asynchronous level; each 0->1 transition requests +1
Depart  input  1  asynchronous level; each 0->1 transition requests -1
Count  output  WIDTH  current occupancy, registered
Full  output  1  registered; high when Count == CAPACITY
Empty  output  1  registered; high when Count == 0
Overflow  output  1  registered one-cycle strobe; arrival rejected at Full
Underflow  output  1  registered one-cycle strobe; departure rejected at Empty

Behaviour:
- Reset: Reset==0 at a rising Clock edge sets the following, overriding all other activity, including an edge in flight:
  - Count=0, Full=0, Empty=1, Overflow=0, Underflow=0.
  - All synchroniser and edge-detect flops cleared to 0.
- Reset release: an input already high when Reset releases counts as a rising edge once it passes the synchroniser (flops reset to 0).
- Input path, per input:
  - SYNC_STAGES-flop synchroniser, then one delay flop.
  - Combinational edge term: rise = sync_out & ~delay.
- Latency (SYNC_STAGES=2): Count/Full/Empty/strobes update on the 3rd rising edge that samples the input high (SYNC_STAGES+1 edges in general).
- Pulse width: an input held high for any duration yields exactly one event. Inputs must stay high at least 2 Clock cycles to be reliably seen.
- Per-cycle decision, with a = arrive rise and d = depart rise:
  - a & ~d & Count<CAPACITY: Count+1.
  - a & ~d & Count==CAPACITY: Count held, Overflow=1 for one cycle.
  - d & ~a & Count>0: Count-1.
  - d & ~a & Count==0: Count held, Underflow=1 for one cycle.
  - a & d: Count held, no strobe (net zero, even at Full or Empty).
  - neither: Count held; Overflow and Underflow return to 0.
- Full and Empty are registered from the next Count value, so they change on the same edge as Count. There is no extra-cycle lag.
- No wrap-around: Count never leaves 0..CAPACITY.
- Small-capacity edge case: with CAPACITY=1, Full and Empty are never both 1.
- Overflow and Underflow are never both 1 in the same cycle.

Decomposition:
- Shared package (ad_counter_pkg): an action enum {ACT_NONE, ACT_INC, ACT_DEC, ACT_OVF, ACT_UNF}, and a function computing the action from (a, d, Count, CAPACITY).
- One natural sub-module: sync_edge_detect (parameter SYNC_STAGES; ports Clock, Reset, In, Rise). It is instantiated once for Arrive and once for Depart.
- The top level holds the counter register, status flags and action decode.

Test Plan:
- Reset held low 3 cycles, then released with inputs low -> Count=0, Empty=1, Full=0, Overflow=0, Underflow=0.
- Arrive high for 5 cycles, then low -> exactly one increment: Count=1 on the 3rd edge after Arrive rises, Empty falls on that same edge.
- 12 separate Arrive pulses (2 cycles high, 2 low), CAPACITY=10:
  - Count reaches 10 and Full=1.
  - Pulses 11 and 12 each give one 1-cycle Overflow strobe, with Count staying 10.
- Count=0, one Depart pulse -> Count stays 0, Underflow=1 for one cycle, Empty stays 1.
- Count=5, Arrive and Depart rising in the same cycle -> Count=5 with no strobe. Then a Depart alone -> Count=4.
- Count=7, an Arrive pulse in flight (synchroniser holding 1), Reset pulled low one edge -> Count=0, Empty=1. No increment after release unless Arrive is still high, in which case Count=1 after SYNC_STAGES+1 edges.

Source files
------------

// File: rtl/ad_counter_pkg.sv
// ---------------------------------------------------------------------------
// ad_counter_pkg
// Shared types and the per-cycle decision rule for arrive_depart_counter.
//
// Contents:
//   action_e       - what the counter does on the current edge
//   decide_action  - maps (arrive rise, depart rise, count, capacity) to an
//                    action_e. Simultaneous rises cancel and produce no strobe.
// ---------------------------------------------------------------------------
package ad_counter_pkg;

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,   // hold count, clear strobes
        ACT_INC  = 3'd1,   // count + 1
        ACT_DEC  = 3'd2,   // count - 1
        ACT_OVF  = 3'd3,   // arrival rejected at capacity
        ACT_UNF  = 3'd4    // departure rejected at zero
    } action_e;

    function automatic action_e decide_action(
        input logic a,
        input logic d,
        input int   count,
        input int   cap
    );
        action_e act;
        act = ACT_NONE;
        if (a && !d) begin
            act = (count >= cap) ? ACT_OVF : ACT_INC;
        end else if (d && !a) begin
            act = (count <= 0) ? ACT_UNF : ACT_DEC;
        end
        return act;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the Clock domain and flags its rising
// edge for exactly one cycle, however long the level stays high.
//
// Ports:
//   Clock  in   system clock
//   Reset  in   synchronous active-low reset; clears every flop
//   In     in   asynchronous level input
//   Rise   out  one-cycle pulse, combinational from the last two flops
//
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic In,
    output logic Rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], In};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Because everything resets to 0, a level already high at reset release
    // is seen as a fresh edge once it emerges from the synchroniser.
    assign Rise = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/arrive_depart_counter.sv
// ---------------------------------------------------------------------------
// arrive_depart_counter
// Saturating occupancy counter driven by two asynchronous sensor levels.
// Each rising edge of Arrive requests +1, each rising edge of Depart -1.
// The count is clamped to 0..CAPACITY; a rejected request raises a
// one-cycle Overflow/Underflow strobe.
//
// Ports:
//   Clock     in   system clock, all state on rising edge
//   Reset     in   synchronous active-low reset
//   Arrive    in   asynchronous level, 0->1 requests +1
//   Depart    in   asynchronous level, 0->1 requests -1
//   Count     out  registered occupancy [WIDTH-1:0]
//   Full      out  registered, Count == CAPACITY
//   Empty     out  registered, Count == 0
//   Overflow  out  registered one-cycle strobe, arrival rejected at Full
//   Underflow out  registered one-cycle strobe, departure rejected at Empty
//
// Input-to-output latency is SYNC_STAGES+1 rising edges.
// ---------------------------------------------------------------------------
module arrive_depart_counter
    import ad_counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int CAPACITY    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Arrive,
    input  logic             Depart,
    output logic [WIDTH-1:0] Count,
    output logic             Full,
    output logic             Empty,
    output logic             Overflow,
    output logic             Underflow
);

    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);

    logic             arr_rise;
    logic             dep_rise;
    action_e          act;

    logic [WIDTH-1:0] count_q, count_d;
    logic             full_q,  full_d;
    logic             empty_q, empty_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_arrive (
        .Clock (Clock),
        .Reset (Reset),
        .In    (Arrive),
        .Rise  (arr_rise)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_depart (
        .Clock (Clock),
        .Reset (Reset),
        .In    (Depart),
        .Rise  (dep_rise)
    );

    assign act = decide_action(arr_rise, dep_rise, int'(count_q), CAPACITY);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        case (act)
            ACT_INC: count_d = count_q + WIDTH'(1);
            ACT_DEC: count_d = count_q - WIDTH'(1);
            ACT_OVF: ovf_d   = 1'b1;
            ACT_UNF: unf_d   = 1'b1;
            default: ;
        endcase
        // Flags come from the next count so they move on the same edge
        // as Count rather than one cycle behind it.
        full_d  = (count_d == CAP_W);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign Count     = count_q;
    assign Full      = full_q;
    assign Empty     = empty_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

    // Structural invariants of the saturating counter.
    a_range:   assert property (@(posedge Clock) disable iff (!Reset) count_q <= CAP_W);
    a_flags:   assert property (@(posedge Clock) disable iff (!Reset) !(full_q && empty_q));
    a_strobes: assert property (@(posedge Clock) disable iff (!Reset) !(ovf_q && unf_q));

endmodule

// File: tb/tb_arrive_depart_counter.sv
module tb_arrive_depart_counter;

    localparam int WIDTH = 4;
    localparam int CAP   = 10;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arrive, depart;
    logic [WIDTH-1:0] count;
    logic             full, empty, ovf, unf;

    arrive_depart_counter #(.WIDTH(WIDTH), .CAPACITY(CAP), .SYNC_STAGES(SS)) dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .Arrive    (arrive),
        .Depart    (depart),
        .Count     (count),
        .Full      (full),
        .Empty     (empty),
        .Overflow  (ovf),
        .Underflow (unf)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int ovf_seen = 0;
    int unf_seen = 0;

    // ---------------- reference model ----------------
    // The model keeps the input levels seen at each rising edge. A request
    // takes effect SS+1 edges after it is first sampled high, provided the
    // sample one edge earlier was low. Reset wipes the remembered history.
    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             full, empty, ovf, unf;
    } exp_t;

    exp_t exp_q[$];
    bit   a_hist[$];
    bit   d_hist[$];
    int   m_cnt;

    task automatic clear_hist();
        a_hist.delete(); d_hist.delete();
        for (int i = 0; i < SS + 1; i++) begin
            a_hist.push_back(1'b0); d_hist.push_back(1'b0);
        end
    endtask

    initial clear_hist();

    always @(posedge clk) begin
        exp_t e;
        bit a, d, o, u;
        o = 0; u = 0;
        if (!rst_n) begin
            m_cnt = 0;
            clear_hist();
        end else begin
            // a_hist[0] = sample from previous edge, a_hist[SS-1] = SS edges ago
            a = a_hist[SS-1] && !a_hist[SS];
            d = d_hist[SS-1] && !d_hist[SS];
            if (a && !d) begin
                if (m_cnt == CAP) o = 1; else m_cnt = m_cnt + 1;
            end else if (d && !a) begin
                if (m_cnt == 0) u = 1; else m_cnt = m_cnt - 1;
            end
            a_hist.push_front(arrive); void'(a_hist.pop_back());
            d_hist.push_front(depart); void'(d_hist.pop_back());
        end
        e.cnt   = WIDTH'(m_cnt);
        e.full  = (m_cnt == CAP);
        e.empty = (m_cnt == 0);
        e.ovf   = o;
        e.unf   = u;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({count, full, empty, ovf, unf} !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got cnt=%0d full=%b empty=%b ovf=%b unf=%b, want cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                         $time, count, full, empty, ovf, unf, e.cnt, e.full, e.empty, e.ovf, e.unf);
            end
            if (ovf === 1'b1) ovf_seen++;
            if (unf === 1'b1) unf_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse(input bit a, input bit d, input int hi, input int lo);
        @(negedge clk);
        arrive = a; depart = d;
        idle(hi);
        arrive = 0; depart = 0;
        idle(lo);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 0;
        idle(n);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; arrive = 0; depart = 0;
        idle(3);
        rst_n = 1;
        idle(1);
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full",  full,  0);

        // long pulse counts once, third edge latency
        @(negedge clk); arrive = 1;
        idle(2);
        chk("latency_before", count, 0);
        idle(1);
        chk("latency_count", count, 1);
        chk("latency_empty", empty, 0);
        idle(2); arrive = 0; idle(4);
        chk("long_pulse_once", count, 1);

        // fill and overflow
        do_reset(1); idle(3);
        ovf_seen = 0;
        for (int i = 0; i < 12; i++) pulse(1, 0, 2, 2);
        idle(4);
        chk("fill_count", count, CAP);
        chk("fill_full",  full, 1);
        chk("ovf_strobes", ovf_seen, 2);

        // underflow at empty
        do_reset(1); idle(3);
        unf_seen = 0;
        pulse(0, 1, 2, 5);
        chk("unf_count", count, 0);
        chk("unf_empty", empty, 1);
        chk("unf_strobes", unf_seen, 1);

        // simultaneous edges at count 5
        do_reset(1); idle(3);
        for (int i = 0; i < 5; i++) pulse(1, 0, 2, 2);
        idle(3);
        ovf_seen = 0; unf_seen = 0;
        pulse(1, 1, 2, 5);
        chk("simul_count", count, 5);
        chk("simul_strobes", ovf_seen + unf_seen, 0);
        pulse(0, 1, 2, 5);
        chk("dep_after_simul", count, 4);

        // reset with arrival in flight, arrive dropped
        do_reset(1); idle(3);
        for (int i = 0; i < 7; i++) pulse(1, 0, 2, 2);
        idle(3);
        chk("pre_flight7", count, 7);
        @(negedge clk); arrive = 1;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1; arrive = 0;
        idle(6);
        chk("flight_dropped", count, 0);
        chk("flight_dropped_empty", empty, 1);

        // reset with arrival in flight, arrive held
        for (int i = 0; i < 7; i++) pulse(1, 0, 2, 2);
        idle(3);
        @(negedge clk); arrive = 1;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        chk("flight_held_t0", count, 0);
        idle(2);
        chk("flight_held_t2", count, 0);
        idle(1);
        chk("flight_held_t3", count, 1);
        arrive = 0; idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) rst_n = 0;
            else rst_n = 1;
            arrive = $urandom_range(0, 99) < 55;
            depart = $urandom_range(0, 99) < 45;
            idle($urandom_range(1, 4));
        end
        rst_n = 1; arrive = 0; depart = 0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
